// File: rtl/mano_irq_pkg.sv
// Shared definitions for the interrupt priority latch.
//   LINES       : number of request lines, fixed at 16 to match the 4-bit encoder
//   line_vec_t  : one bit per request line
//   irq_state_t : offer handshake state (IDLE / OFFER)
package mano_irq_pkg;

   localparam int LINES = 16;

   typedef logic [LINES-1:0] line_vec_t;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } irq_state_t;

endpackage

// File: rtl/priority_pick16.sv
// Combinational lowest-index-wins one-hot selector.
//   req  : in  16  candidate lines
//   pick : out 16  one-hot lowest set bit of req, all-zero when req is zero
module priority_pick16
   import mano_irq_pkg::*;
(
   input  logic [LINES-1:0] req,
   output logic [LINES-1:0] pick
);

   genvar gi;
   generate
      for (gi = 0; gi < LINES; gi++) begin : g_pick
         if (gi == 0) begin : g_first
            assign pick[gi] = req[gi];
         end else begin : g_rest
            // A line wins only when no lower-index line is requesting.
            assign pick[gi] = req[gi] & ~(|req[gi-1:0]);
         end
      end
   endgenerate

endmodule

// File: rtl/irq_priority_latch.sv
// Interrupt request capture and one-at-a-time grant offer.
//   clock       : in   1   system clock, rising edge
//   reset       : in   1   synchronous active-high reset
//   request_in  : in   16  device request levels; 0->1 raises a request
//   mask_we     : in   1   load mask_in into the mask register
//   mask_in     : in   16  1 = line eligible for grant
//   enable_in   : in   1   global interrupt enable
//   ack_in      : in   1   sequencer accepted the offered grant
//   grant_out   : out  16  one-hot grant (zero when no offer), feeds encoder data_in
//   valid_out   : out  1   grant_out holds a live offer
//   pending_out : out  16  raw pending register
module irq_priority_latch
   import mano_irq_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [LINES-1:0] request_in,
   input  logic             mask_we,
   input  logic [LINES-1:0] mask_in,
   input  logic             enable_in,
   input  logic             ack_in,
   output logic [LINES-1:0] grant_out,
   output logic             valid_out,
   output logic [LINES-1:0] pending_out
);

   line_vec_t  req_q_reg;
   line_vec_t  pending_reg;
   line_vec_t  pending_next;
   line_vec_t  mask_reg;
   line_vec_t  grant_reg;
   line_vec_t  grant_next;
   irq_state_t state_reg;
   irq_state_t state_next;

   line_vec_t  rise;
   line_vec_t  clr;
   line_vec_t  eligible;
   line_vec_t  pick;

   // Edge detect. req_q resets to all ones so lines already high when reset
   // releases are not mistaken for fresh requests.
   assign rise     = request_in & ~req_q_reg;
   // Masked lines are still captured into pending; they just cannot win.
   assign eligible = pending_reg & mask_reg;

   priority_pick16 u_pick (
      .req  (eligible),
      .pick (pick)
   );

   // State register and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         req_q_reg   <= '1;
         pending_reg <= '0;
         mask_reg    <= '0;
         grant_reg   <= '0;
         state_reg   <= IDLE;
      end else begin
         req_q_reg   <= request_in;
         pending_reg <= pending_next;
         if (mask_we) begin
            mask_reg <= mask_in;
         end
         grant_reg   <= grant_next;
         state_reg   <= state_next;
      end
   end

   // Next-state logic. The grant register only loads on the IDLE->OFFER
   // transition, so neither a mask write nor a new higher-priority rise can
   // disturb an offer already on the bus.
   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      clr        = '0;
      case (state_reg)
         IDLE: begin
            if (enable_in && (|eligible)) begin
               state_next = OFFER;
               grant_next = pick;
            end
         end
         OFFER: begin
            // ack has priority over a same-cycle enable drop.
            if (ack_in) begin
               clr        = grant_reg;
               state_next = IDLE;
            end else if (!enable_in) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // Set wins over clear when the granted line re-rises on the ack cycle.
      pending_next = (pending_reg & ~clr) | rise;
   end

   // Output logic.
   always_comb begin
      grant_out = '0;
      valid_out = 1'b0;
      if (state_reg == OFFER) begin
         grant_out = grant_reg;
         valid_out = 1'b1;
      end
   end

   assign pending_out = pending_reg;

endmodule
